// File: rtl/btn_event_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : btn_event_ctrl
// Purpose  : Classifies debounced button presses into short, long and
//            double-press events; drives a status LED and a press counter.
// Revision : 1.0 - initial release
// ============================================================================
module btn_event_ctrl #(
  parameter int LONG_CYCLES = 16,
  parameter int DBL_WINDOW  = 8,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             db_in,
  output logic             press_pulse,
  output logic             short_evt,
  output logic             long_evt,
  output logic             double_evt,
  output logic [CNT_W-1:0] press_cnt,
  output logic             led,
  output logic             busy
);

  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int GAP_W  = $clog2(DBL_WINDOW + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(DBL_WINDOW);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_PRESSED     = 3'd1;
  localparam logic [2:0] S_LONG_HELD   = 3'd2;
  localparam logic [2:0] S_WAIT_SECOND = 3'd3;
  localparam logic [2:0] S_SECOND_HELD = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic [GAP_W-1:0]  gap_cnt;
  logic [GAP_W-1:0]  gap_next;
  logic              db_q;
  logic              rise;
  logic              fall;
  logic              short_set;
  logic              long_set;
  logic              double_set;

  // db_q resets high so a button held through reset is not seen as a new press
  assign rise = db_in & ~db_q;
  assign fall = ~db_in & db_q;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      gap_cnt  <= gap_next;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    gap_next   = gap_cnt;
    case (state)
      S_IDLE: begin
        if (rise) begin
          state_next = S_PRESSED;
          hold_next  = HOLD_W'(1);
        end
      end
      S_PRESSED: begin
        if (!db_in) begin
          state_next = S_WAIT_SECOND;
          gap_next   = GAP_W'(1);
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = S_LONG_HELD;
        end else begin
          hold_next = hold_cnt + HOLD_W'(1);
        end
      end
      S_LONG_HELD: begin
        if (fall) state_next = S_IDLE;
      end
      S_WAIT_SECOND: begin
        // A rise landing on the expiry edge still counts as a double press
        if (rise) begin
          state_next = S_SECOND_HELD;
        end else if (gap_cnt == GAP_LAST) begin
          state_next = S_IDLE;
        end else begin
          gap_next = gap_cnt + GAP_W'(1);
        end
      end
      S_SECOND_HELD: begin
        if (fall) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Event decode from the current state and inputs
  always_comb begin
    short_set  = 1'b0;
    long_set   = 1'b0;
    double_set = 1'b0;
    case (state)
      S_PRESSED: begin
        long_set = db_in && (hold_cnt == HOLD_LAST);
      end
      S_WAIT_SECOND: begin
        double_set = rise;
        short_set  = !rise && (gap_cnt == GAP_LAST);
      end
      default: begin
        short_set  = 1'b0;
      end
    endcase
  end

  // Registered outputs, edge detector and press counter
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q        <= 1'b1;
      press_pulse <= 1'b0;
      press_cnt   <= '0;
      short_evt   <= 1'b0;
      long_evt    <= 1'b0;
      double_evt  <= 1'b0;
      led         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      db_q        <= db_in;
      press_pulse <= rise;
      if (rise) press_cnt <= press_cnt + CNT_W'(1);
      short_evt   <= short_set;
      long_evt    <= long_set;
      double_evt  <= double_set;
      if (short_set)       led <= ~led;
      else if (double_set) led <= 1'b1;
      else if (long_set)   led <= 1'b0;
      busy        <= (state_next != S_IDLE);
    end
  end

endmodule
`default_nettype wire
